lfsr_rand_arb: RTL and testbench
================================

# lfsr_rand_arb

Pseudo-random arbiter that shares one resource between `NREQ` requesters. Each arbitration starts its search at an index taken from an internal 16-bit Fibonacci LFSR. It sits in front of shared structures (replacement port, shared ALU slot, bus master) where a fixed or round-robin priority would cause pathological starvation patterns. The grant is held until the owner releases it or a watchdog forces it free.

## Interface
- `NREQ`, 4: number of requesters; must be a power of 2 in the range 2..16. `LOG = log2(NREQ)`.
- `INITVAL`, 16'he45b: LFSR reset value; must be non-zero.
- `MAXHOLD`, 8: maximum cycles a grant is held before forced release. Range 1..255.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset; synchronous, active-low (reset applied on a posedge where `rst==0`).
- `req`  in  NREQ  request level per requester; held high until granted.
- `done`  in  NREQ  release pulse from the current owner.
- `seed_wr`  in  1  load `seed` into the LFSR this cycle.
- `seed`  in  16  new LFSR value; a value of zero is replaced by `INITVAL`.
- `gnt`  out  NREQ  one-hot grant, registered.
- `gnt_vld`  out  1  equals `|gnt`.
- `gnt_id`  out  LOG  binary index of the owner; 0 when not granted.
- `timeout`  out  1  one-cycle pulse when a forced release occurs.
- `lfsr_q`  out  16  current LFSR state, for debug and for reuse by the owner.

## Operation
- **LFSR:** `fb = q[15]^q[13]^q[12]^q[10]`, then `q <= {q[14:0],fb}`. Steps every cycle. When `seed_wr` is asserted it loads instead of stepping; `seed_wr` has priority over stepping.
- **Reset values:** `q=INITVAL`, `gnt=0`, `gnt_vld=0`, `gnt_id=0`, `timeout=0`, state=IDLE, hold counter=0.
- **FSM states:** IDLE, OWNED, COOL.
- **IDLE:**
  - If `|req`, set `start = q[LOG-1:0]`. The winner is the first `i` with `req[i]` set, searching `start, start+1, …` modulo `NREQ`.
  - Next edge: `gnt = onehot(winner)`, `gnt_id = winner`, hold counter=0, go to OWNED.
  - If no request, stay in IDLE.
- **OWNED:**
  - Release occurs when `done[gnt_id]` is 1 or `req[gnt_id]` is 0. On the next edge `gnt` clears and the state goes to COOL.
  - Otherwise the counter increments. When counter reaches `MAXHOLD-1` without a release, the next edge clears `gnt`, pulses `timeout`, and goes to COOL.
  - `done`/`req` bits of non-owners are ignored.
- **COOL:** one dead cycle with no grant. Unconditionally returns to IDLE. This guarantees a gap of at least one cycle between owners.
- **Simultaneous events:**
  - Release and the timeout threshold in the same cycle: treat as a normal release, with no `timeout` pulse.
  - `seed_wr` in IDLE with a request: arbitration uses the pre-load `q`.
- **Reset mid-grant:** `gnt` drops at that edge and there is no `timeout` pulse.

## Timing
- Request-to-grant latency: 1 cycle from the IDLE cycle in which `req` is seen.
- Release-to-next-grant: release cycle, then COOL, then IDLE sample, then grant. Minimum 3 edges from the `done` edge to a new `gnt`.
- Maximum hold: `MAXHOLD` cycles of `gnt` high.
- `lfsr_q` reflects the register value, changing 1 edge after `seed_wr`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- **Shared package:**
  - `LFSR_TAPS = 16'hB400` (bits 15, 13, 12, 10).
  - FSM state encoding: `ARB_IDLE=2'd0`, `ARB_OWNED=2'd1`, `ARB_COOL=2'd2`.
  - A `clog2` helper.
- **Sub-module `lfsr16_step`:** combinational next-state function `(q, seed_wr, seed) -> q_next`, including the zero-seed substitution. It is reusable by other random-replacement blocks.
- **Rotating search:** done in the arbiter body by double-width request rotation.

## Test plan
- **Reset and LFSR step:** hold `rst=0` for 2 cycles, then release. Required: `lfsr_q=16'he45b`, then `16'hc8b7` one edge later, and `gnt=0` throughout reset.
- **Single requester:** `req=4'b0100` in IDLE. Required: next edge `gnt=4'b0100`, `gnt_id=2`, `gnt_vld=1`. After `done[2]` pulses: `gnt=0` next edge, one COOL cycle, and no regrant until the IDLE sample.
- **All requesting, seeded:** `seed_wr=1` with `seed=16'h0003`, then `req=4'b1111` while `lfsr_q=16'h0003` in IDLE. Required: `gnt_id=3`. Then seed `16'h0004`. Required: `gnt_id=0`.
- **Watchdog:** `MAXHOLD=8`, owner never releases. Required: `gnt` high for exactly 8 cycles, a one-cycle `timeout` pulse on the clearing edge, then COOL.
- **Zero seed and collision:** `seed_wr` with `seed=0`. Required: `lfsr_q=16'he45b`. `done[owner]` on the same cycle as the timeout threshold. Required: `timeout` stays 0.
- **Mid-grant reset and req drop:** assert `rst=0` while OWNED. Required: all outputs at reset values next edge. Separately, the owner drops `req` without `done`. Required: release identical to the `done` case.

Source files
------------

// File: rtl/lfsr_rand_arb_pkg.sv
// Shared definitions for the LFSR-seeded random arbiter: tap mask, FSM
// encoding and a width helper usable in parameter expressions.
package lfsr_rand_arb_pkg;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWNED = 2'd1,
        ARB_COOL  = 2'd2
    } arb_state_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/lfsr_rand_arb_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface lfsr_rand_arb_if #(
    parameter int NREQ = 4
) ();
    import lfsr_rand_arb_pkg::*;

    localparam int LOG = clog2(NREQ);

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] done;
    logic [NREQ-1:0] gnt;
    logic            gnt_vld;
    logic [LOG-1:0]  gnt_id;
    logic            timeout;

    modport master (
        output req, done,
        input  gnt, gnt_vld, gnt_id, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_vld, gnt_id, timeout
    );

endinterface

// File: rtl/lfsr16_step.sv
// Next-state function of the 16-bit Fibonacci LFSR, with seed load taking
// priority over stepping and an all-zero seed mapped to INITVAL.
module lfsr16_step
    import lfsr_rand_arb_pkg::*;
#(
    parameter logic [15:0] INITVAL = 16'he45b
) (
    input  logic [15:0] q,
    input  logic        seed_wr,
    input  logic [15:0] seed,
    output logic [15:0] q_next
);

    logic fb;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        fb     = ^(q & LFSR_TAPS);
        q_next = {q[14:0], fb};
        if (seed_wr) begin
            // An all-zero state would lock the LFSR up forever.
            q_next = (seed == 16'd0) ? INITVAL : seed;
        end
    end

endmodule

// File: rtl/lfsr_rand_arb.sv
// Random-start arbiter: the search origin comes from the LFSR, the grant is
// held until release or watchdog expiry, and a cool cycle separates owners.
module lfsr_rand_arb
    import lfsr_rand_arb_pkg::*;
#(
    parameter int          NREQ    = 4,
    parameter logic [15:0] INITVAL = 16'he45b,
    parameter int          MAXHOLD = 8
) (
    input  logic           clk,
    input  logic           rst,
    lfsr_rand_arb_if.slave arb,
    input  logic           seed_wr,
    input  logic [15:0]    seed,
    output logic [15:0]    lfsr_q
);

    localparam int         LOG       = clog2(NREQ);
    localparam logic [7:0] HOLD_LAST = 8'(MAXHOLD - 1);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            gnt_vld_q, gnt_vld_d;
    logic [LOG-1:0]  gnt_id_q, gnt_id_d;
    logic            timeout_q, timeout_d;
    logic [7:0]      hold_q, hold_d;
    logic [15:0]     lfsr_d;

    logic [LOG-1:0]    start;
    logic [LOG-1:0]    offset;
    logic [LOG-1:0]    winner;
    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic              release_own;

    lfsr16_step #(.INITVAL(INITVAL)) u_step (
        .q      (lfsr_q),
        .seed_wr(seed_wr),
        .seed   (seed),
        .q_next (lfsr_d)
    );

    // Rotate requests so bit 0 is the LFSR-chosen start, pick the lowest set
    // bit, then rotate the offset back; NREQ is a power of two so it wraps.
    always_comb begin
        start   = lfsr_q[LOG-1:0];
        req_dbl = {arb.req, arb.req};
        req_rot = NREQ'(req_dbl >> start);
        offset  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) offset = LOG'(i);
        end
        winner = start + offset;
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        hold_d      = hold_q;
        timeout_d   = 1'b0;
        release_own = arb.done[gnt_id_q] | ~arb.req[gnt_id_q];

        case (state_q)
            ARB_IDLE: begin
                if (|arb.req) begin
                    gnt_d    = NREQ'(1) << winner;
                    gnt_id_d = winner;
                    hold_d   = '0;
                    state_d  = ARB_OWNED;
                end
            end
            ARB_OWNED: begin
                // A release on the threshold cycle wins over the watchdog.
                if (release_own) begin
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    state_d  = ARB_COOL;
                end else if (hold_q == HOLD_LAST) begin
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = ARB_COOL;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            ARB_COOL: begin
                hold_d  = '0;
                state_d = ARB_IDLE;
            end
            default: begin
                gnt_d    = '0;
                gnt_id_d = '0;
                hold_d   = '0;
                state_d  = ARB_IDLE;
            end
        endcase

        gnt_vld_d = |gnt_d;
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (!rst) begin
            state_q   <= ARB_IDLE;
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
            gnt_id_q  <= '0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
            lfsr_q    <= INITVAL;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_vld_q <= gnt_vld_d;
            gnt_id_q  <= gnt_id_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
            lfsr_q    <= lfsr_d;
        end
    end

    assign arb.gnt     = gnt_q;
    assign arb.gnt_vld = gnt_vld_q;
    assign arb.gnt_id  = gnt_id_q;
    assign arb.timeout = timeout_q;

endmodule

// File: tb/tb_lfsr_rand_arb.sv
// Self-checking bench for lfsr_rand_arb: directed corner sequences, a seeded
// vector table, then random traffic against a behavioural arbiter model.
module tb_lfsr_rand_arb;
    import lfsr_rand_arb_pkg::*;

    localparam int          NREQ    = 4;
    localparam int          MAXHOLD = 8;
    localparam logic [15:0] INITVAL = 16'he45b;

    logic        clk = 1'b0;
    logic        rst;
    logic        seed_wr;
    logic [15:0] seed;
    logic [15:0] lfsr_q;

    lfsr_rand_arb_if #(.NREQ(NREQ)) arb_if ();

    lfsr_rand_arb #(
        .NREQ   (NREQ),
        .INITVAL(INITVAL),
        .MAXHOLD(MAXHOLD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .arb    (arb_if),
        .seed_wr(seed_wr),
        .seed   (seed),
        .lfsr_q (lfsr_q)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: owner index (-1 = none), cool flag, cycles held.
    logic [15:0] m_lfsr;
    int          m_owner;
    bit          m_cool;
    int          m_held;
    bit          m_to;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    task automatic model_step();
        int s;
        int w;
        if (!rst) begin
            m_lfsr  = INITVAL;
            m_owner = -1;
            m_cool  = 1'b0;
            m_held  = 0;
            m_to    = 1'b0;
            return;
        end
        m_to = 1'b0;
        if (m_cool) begin
            m_cool = 1'b0;
        end else if (m_owner < 0) begin
            if (arb_if.req != 0) begin
                s = int'(m_lfsr) % NREQ;
                w = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (w < 0 && arb_if.req[(s + k) % NREQ]) w = (s + k) % NREQ;
                end
                m_owner = w;
                m_held  = 1;
            end
        end else if (arb_if.done[m_owner] || !arb_if.req[m_owner]) begin
            m_owner = -1;
            m_cool  = 1'b1;
        end else if (m_held == MAXHOLD) begin
            m_owner = -1;
            m_cool  = 1'b1;
            m_to    = 1'b1;
        end else begin
            m_held++;
        end
        m_lfsr = seed_wr ? ((seed == 16'd0) ? INITVAL : seed) : lfsr_next(m_lfsr);
    endtask

    typedef struct {
        logic [15:0] seed;
        logic [3:0]  req;
        logic [15:0] exp_lfsr;
        logic [1:0]  exp_id;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int          high;
        logic [3:0]  exp_gnt;
        logic [23:0] exp_pack;
        logic [23:0] act_pack;

        vecs[0] = '{16'h0003, 4'b1111, 16'h0003, 2'd3};
        vecs[1] = '{16'h0004, 4'b1111, 16'h0004, 2'd0};
        vecs[2] = '{16'h0001, 4'b0100, 16'h0001, 2'd2};
        vecs[3] = '{16'h0002, 4'b0011, 16'h0002, 2'd0};
        vecs[4] = '{16'h0003, 4'b0110, 16'h0003, 2'd1};
        vecs[5] = '{16'h0000, 4'b1010, 16'he45b, 2'd3};
        vecs[6] = '{16'h0005, 4'b1001, 16'h0005, 2'd3};
        vecs[7] = '{16'h0002, 4'b0100, 16'h0002, 2'd2};

        rst         = 1'b0;
        seed_wr     = 1'b0;
        seed        = '0;
        arb_if.req  = 4'b1111;
        arb_if.done = '0;

        // Reset held two cycles with requests pending, then LFSR steps once.
        tick();
        check("rst_gnt_1", arb_if.gnt, 0);
        tick();
        check("rst_gnt_2", arb_if.gnt, 0);
        check("rst_vld", arb_if.gnt_vld, 0);
        check("rst_id", arb_if.gnt_id, 0);
        check("rst_timeout", arb_if.timeout, 0);
        check("rst_lfsr", lfsr_q, 16'he45b);
        arb_if.req = '0;
        rst        = 1'b1;
        tick();
        check("lfsr_step", lfsr_q, 16'hc8b7);
        check("idle_gnt", arb_if.gnt, 0);

        // Single requester, done release, cool gap, regrant, then req-drop release.
        arb_if.req = 4'b0100;
        tick();
        check("single_gnt", arb_if.gnt, 4'b0100);
        check("single_id", arb_if.gnt_id, 2);
        check("single_vld", arb_if.gnt_vld, 1);
        arb_if.done = 4'b0100;
        tick();
        arb_if.done = '0;
        check("done_clear", arb_if.gnt, 0);
        check("done_vld", arb_if.gnt_vld, 0);
        tick();
        check("cool_no_gnt", arb_if.gnt, 0);
        tick();
        check("regrant", arb_if.gnt, 4'b0100);
        arb_if.req = '0;
        tick();
        check("reqdrop_clear", arb_if.gnt, 0);
        check("reqdrop_timeout", arb_if.timeout, 0);
        tick();
        check("reqdrop_cool", arb_if.gnt, 0);

        // Seeded vector table; each row starts and ends in IDLE.
        for (int v = 0; v < 8; v++) begin
            seed_wr = 1'b1;
            seed    = vecs[v].seed;
            tick();
            seed_wr    = 1'b0;
            check($sformatf("vec%0d_lfsr", v), lfsr_q, vecs[v].exp_lfsr);
            arb_if.req = vecs[v].req;
            tick();
            check($sformatf("vec%0d_id", v), arb_if.gnt_id, vecs[v].exp_id);
            exp_gnt = 4'b0001 << vecs[v].exp_id;
            check($sformatf("vec%0d_gnt", v), arb_if.gnt, exp_gnt);
            arb_if.done = exp_gnt;
            arb_if.req  = '0;
            tick();
            arb_if.done = '0;
            tick();
        end

        // Watchdog: owner never releases.
        arb_if.req = 4'b0001;
        tick();
        check("wd_grant", arb_if.gnt, 4'b0001);
        high = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (arb_if.gnt == 0) break;
            high++;
            check("wd_no_early_timeout", arb_if.timeout, 0);
        end
        check("wd_hold_cycles", high, MAXHOLD);
        check("wd_timeout_pulse", arb_if.timeout, 1);
        arb_if.req = '0;
        tick();
        check("wd_timeout_once", arb_if.timeout, 0);
        check("wd_cool_gnt", arb_if.gnt, 0);

        // Zero seed, then release on the watchdog threshold cycle.
        seed_wr = 1'b1;
        seed    = 16'h0000;
        tick();
        seed_wr = 1'b0;
        check("zero_seed", lfsr_q, 16'he45b);
        arb_if.req = 4'b0010;
        tick();
        check("coll_grant", arb_if.gnt, 4'b0010);
        for (int i = 0; i < MAXHOLD - 1; i++) tick();
        check("coll_still_held", arb_if.gnt, 4'b0010);
        arb_if.done = 4'b0010;
        tick();
        arb_if.done = '0;
        arb_if.req  = '0;
        check("coll_clear", arb_if.gnt, 0);
        check("coll_no_timeout", arb_if.timeout, 0);
        tick();

        // Reset while a grant is held.
        arb_if.req = 4'b1000;
        tick();
        check("mid_grant", arb_if.gnt, 4'b1000);
        tick();
        rst = 1'b0;
        tick();
        check("mid_rst_gnt", arb_if.gnt, 0);
        check("mid_rst_vld", arb_if.gnt_vld, 0);
        check("mid_rst_id", arb_if.gnt_id, 0);
        check("mid_rst_timeout", arb_if.timeout, 0);
        check("mid_rst_lfsr", lfsr_q, 16'he45b);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) arb_if.req = 4'($urandom);
            arb_if.done = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
            seed_wr     = ($urandom_range(0, 15) == 0);
            seed        = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            rst         = (c == 0) ? 1'b0 : ($urandom_range(0, 299) != 0);
            model_step();
            tick();
            exp_gnt  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
            exp_pack = {exp_gnt, (m_owner >= 0) ? 2'(m_owner) : 2'd0,
                        (m_owner >= 0), m_to, m_lfsr};
            act_pack = {arb_if.gnt, arb_if.gnt_id, arb_if.gnt_vld, arb_if.timeout, lfsr_q};
            check($sformatf("rand_c%0d", c), act_pack, exp_pack);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
